// File: rtl/tdm_demux_1x4_if.sv
// TDM input stream bundle: data word, valid qualifier, slot-0 sync.
// master drives the stream, slave (the demux) consumes it.
interface tdm_demux_1x4_if #(
  parameter int n = 4
);
  logic [n-1:0] Din;
  logic         valid;
  logic         sync;

  modport master (output Din, valid, sync);
  modport slave  (input  Din, valid, sync);
endinterface

// File: rtl/tdm_demux_1x4.sv
// 1x4 TDM demux: rebuilds channels A..D from a slot-ordered word stream.
// Ports: clk, rst_n, bus (Din/valid/sync), A..D, S, frame_valid, sync_err, locked.
module tdm_demux_1x4 #(
  parameter int n = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tdm_demux_1x4_if.slave       bus,
  output logic [n-1:0]         A,
  output logic [n-1:0]         B,
  output logic [n-1:0]         C,
  output logic [n-1:0]         D,
  output logic [1:0]           S,
  output logic                 frame_valid,
  output logic                 sync_err,
  output logic                 locked
);

  typedef enum logic {
    HUNT,
    RUN
  } state_t;

  state_t       state;
  // Slot 3 never needs a shadow: it goes straight from Din to D.
  logic [n-1:0] sh [3];

  assign locked = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      S           <= 2'd0;
      sh[0]       <= '0;
      sh[1]       <= '0;
      sh[2]       <= '0;
      A           <= '0;
      B           <= '0;
      C           <= '0;
      D           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (bus.valid) begin
        unique case (1'b1)
          state == HUNT: begin
            if (bus.sync) begin
              sh[0] <= bus.Din;
              S     <= 2'd1;
              state <= RUN;
            end
          end
          bus.sync && S != 2'd0: begin
            // Realign: drop the partial frame, restart at slot 0.
            sync_err <= 1'b1;
            sh[0]    <= bus.Din;
            S        <= 2'd1;
          end
          default: begin
            unique case (S)
              2'd0: sh[0] <= bus.Din;
              2'd1: sh[1] <= bus.Din;
              2'd2: sh[2] <= bus.Din;
              2'd3: begin
                A           <= sh[0];
                B           <= sh[1];
                C           <= sh[2];
                D           <= bus.Din;
                frame_valid <= 1'b1;
              end
            endcase
            S <= S + 2'd1;
          end
        endcase
      end
    end
  end

endmodule
